// File: rtl/ahb_sram_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ahb_sram_slave
// Description : Byte-addressed AHB-Lite SRAM slave with programmable wait
//               states and two-cycle ERROR responses. Used as DMA
//               source/destination memory and as the channel-descriptor store.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               hsel          - slave select
//               haddr         - byte address (offset = haddr[27:0])
//               htrans        - transfer type (IDLE/BUSY/NONSEQ/SEQ)
//               hwrite, hsize - direction and transfer size
//               hreadyin      - bus-level HREADY
//               hwdata, wstrb - write data and byte-lane enables (data phase)
//               hrdata        - registered read data
//               hreadyout     - 0 extends the data phase
//               hresp         - 00 OKAY, 01 ERROR
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic        hreadyin,
    input  logic [31:0] hwdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic [1:0]  hresp
);

    localparam int         c_addr_w    = $clog2(MEM_DEPTH);
    localparam int         c_word_w    = c_addr_w - 2;
    localparam logic [3:0] c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [c_word_w-1:0] r_word;
    logic [c_word_w-1:0] w_rd_word;
    logic                r_write;
    logic                r_wp;
    logic                w_wp_nxt;
    logic                w_load_rd;
    logic                w_capture;
    logic [31:0]         r_hrdata;
    logic [31:0]         w_rd_data;
    logic                w_accept;
    logic                w_err;
    logic                w_fwd;
    logic                w_unused;

    logic [7:0] mem [0:MEM_DEPTH-1];

    // Bits above the 28-bit offset belong to the external decoder.
    assign w_unused = &{1'b0, haddr[31:28]};

    assign w_accept = hsel & hreadyin & htrans[1];

    assign w_err = (|haddr[27:c_addr_w])
                 | (hsize > 3'b010)
                 | ((hsize == 3'b001) & haddr[0])
                 | ((hsize == 3'b010) & (haddr[1:0] != 2'b00));

    assign hrdata = r_hrdata;

    // r_wp marks the final OKAY cycle of a write: its commit happens on the
    // same edge that may load a zero-wait read of the same word, so the
    // written lanes are taken straight from the bus.
    assign w_fwd = r_wp & (r_word == w_rd_word);

    always_comb begin
        w_rd_data = '0;
        for (int n = 0; n < 4; n++) begin
            w_rd_data[8*n +: 8] = (w_fwd & wstrb[n]) ? hwdata[8*n +: 8]
                                                     : mem[{w_rd_word, 2'(n)}];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wp_nxt    = 1'b0;
        w_load_rd   = 1'b0;
        w_capture   = 1'b0;
        w_rd_word   = r_word;
        hreadyout   = 1'b1;
        hresp       = 2'b00;
        case (r_state)
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                    w_wp_nxt    = r_write;
                    w_load_rd   = ~r_write;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_ERR1: begin
                hreadyout   = 1'b0;
                hresp       = 2'b01;
                w_state_nxt = ST_ERR2;
            end
            default: begin
                // IDLE and ERR2 both end a data phase, so both accept.
                if (r_state == ST_ERR2) begin
                    hresp = 2'b01;
                end
                w_state_nxt = ST_IDLE;
                if (w_accept) begin
                    w_capture = 1'b1;
                    w_rd_word = haddr[c_addr_w-1:2];
                    if (w_err) begin
                        w_state_nxt = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = c_wait_load;
                    end else begin
                        w_wp_nxt  = hwrite;
                        w_load_rd = ~hwrite;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_word   <= '0;
            r_write  <= 1'b0;
            r_wp     <= 1'b0;
            r_hrdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wp    <= w_wp_nxt;
            if (w_capture) begin
                r_word  <= haddr[c_addr_w-1:2];
                r_write <= hwrite;
            end
            if (w_load_rd) begin
                r_hrdata <= w_rd_data;
            end
        end
    end

    // Storage is never cleared; a reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && r_wp) begin
            for (int n = 0; n < 4; n++) begin
                if (wstrb[n]) begin
                    mem[{r_word, 2'(n)}] <= hwdata[8*n +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ahb_sram_slave
// Description : Self-checking bench for ahb_sram_slave. Two instances share
//               one bus (zero-wait and two-wait-state); a transaction-level
//               byte-array model supplies expected responses and read data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;

    localparam int DEPTH = 256;
    localparam int WS2   = 2;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        hand;
        logic        exp_err;
        logic [31:0] erd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel0, hsel2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [3:0]  wstrb;
    logic [31:0] hrdata0, hrdata2;
    logic        rdy0, rdy2;
    logic [1:0]  resp0, resp2;
    logic        hready_bus;

    always #5 clk = ~clk;

    assign hready_bus = rdy0 & rdy2;

    ahb_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hreadyin(hready_bus), .hwdata(hwdata),
        .wstrb(wstrb), .hrdata(hrdata0), .hreadyout(rdy0), .hresp(resp0)
    );

    ahb_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(WS2)) dut2 (
        .clk(clk), .rst(rst), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hreadyin(hready_bus), .hwdata(hwdata),
        .wstrb(wstrb), .hrdata(hrdata2), .hreadyout(rdy2), .hresp(resp2)
    );

    // Reference model: one byte array per instance plus the expected hrdata.
    logic [7:0]  mdl [2][DEPTH];
    logic [31:0] exp_hr [2];
    vec_t        vq [$];
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, expected %h (t=%0t)", nm, idx, act, exp, $time);
    endtask

    function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
        return (a[27:0] >= 28'(DEPTH)) || (s > 3'd2) || (s == 3'd1 && a[0])
            || (s == 3'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] mdl_rd(input int t, input logic [31:0] a);
        int b;
        b = int'(a[7:0]) & ~3;
        return {mdl[t][b+3], mdl[t][b+2], mdl[t][b+1], mdl[t][b]};
    endfunction

    task automatic mdl_wr(input int t, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        int b;
        b = int'(a[7:0]) & ~3;
        for (int n = 0; n < 4; n++) if (s[n]) mdl[t][b+n] = d[8*n +: 8];
    endtask

    function automatic vec_t mk(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                                input logic w, input logic [2:0] s, input logic [31:0] d,
                                input logic [3:0] st, input logic eerr, input logic [31:0] erd);
        vec_t v;
        v.sel = sel; v.trans = tr; v.addr = a; v.write = w; v.size = s;
        v.wdata = d; v.strb = st; v.hand = 1'b1; v.exp_err = eerr; v.erd = erd;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t        v;
        logic [27:0] off;
        v.sel   = ($urandom_range(0, 9) != 0);
        v.trans = ($urandom_range(0, 9) < 8) ? 2'(2 + $urandom_range(0, 1))
                                             : 2'($urandom_range(0, 1));
        v.size  = ($urandom_range(0, 9) != 0) ? 3'($urandom_range(0, 2))
                                              : 3'($urandom_range(3, 7));
        case ($urandom_range(0, 19))
            0:       off = 28'($urandom_range(256, 511));
            1:       off = 28'($urandom) | 28'h100;
            2:       off = 28'($urandom_range(240, 255));
            default: off = 28'($urandom_range(0, 63));
        endcase
        if ($urandom_range(0, 3) != 0) begin
            if (v.size == 3'd1) off[0] = 1'b0;
            else if (v.size == 3'd2) off[1:0] = 2'b00;
        end
        v.addr    = {4'($urandom), off};
        v.write   = 1'($urandom);
        v.wdata   = $urandom;
        v.strb    = 4'($urandom);
        v.hand    = 1'b0;
        v.exp_err = 1'b0;
        v.erd     = 32'd0;
        return v;
    endfunction

    function automatic logic get_rdy(input int t);  return (t == 0) ? rdy0 : rdy2;       endfunction
    function automatic logic [1:0] get_resp(input int t); return (t == 0) ? resp0 : resp2; endfunction
    function automatic logic [31:0] get_rd(input int t);  return (t == 0) ? hrdata0 : hrdata2; endfunction

    task automatic bus_idle();
        hsel0 = 1'b0; hsel2 = 1'b0; haddr = 32'd0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
    endtask

    // Pipelined bus master for instance t (0 = zero-wait, 1 = WS2), applying vq.
    task automatic run(input int t);
        int         ai, di, k, len, guard, o;
        bit         de, rdy, issued;
        logic [1:0] rsp;
        o = 1 - t; ai = 0; di = -1; k = 0; len = 1; de = 1'b0; guard = 0;
        while ((ai < vq.size() || di >= 0) && guard < 20000) begin
            guard++;
            if (di < 0)  begin rdy = 1'b1; rsp = 2'b00; end
            else if (de) begin rdy = (k == 1); rsp = 2'b01; end
            else         begin rdy = (k == len - 1); rsp = 2'b00; end
            if (di >= 0 && !de && rdy && !vq[di].write)
                exp_hr[t] = vq[di].hand ? vq[di].erd : mdl_rd(t, vq[di].addr);
            check("hreadyout", di, 32'(get_rdy(t)), 32'(rdy));
            check("hresp", di, 32'(get_resp(t)), 32'(rsp));
            check("hrdata", di, get_rd(t), exp_hr[t]);
            check("other_hreadyout", di, 32'(get_rdy(o)), 32'd1);
            check("other_hresp", di, 32'(get_resp(o)), 32'd0);
            check("other_hrdata", di, get_rd(o), exp_hr[o]);
            if (di >= 0 && !de && rdy && vq[di].write)
                mdl_wr(t, vq[di].addr, vq[di].wdata, vq[di].strb);
            if (di >= 0 && vq[di].write) begin
                hwdata = vq[di].wdata; wstrb = vq[di].strb;
            end else begin
                hwdata = $urandom; wstrb = 4'($urandom);
            end
            issued = 1'b0;
            if (rdy && ai < vq.size()) begin
                hsel0 = (t == 0) ? vq[ai].sel : 1'b0;
                hsel2 = (t == 1) ? vq[ai].sel : 1'b0;
                haddr = vq[ai].addr; htrans = vq[ai].trans;
                hwrite = vq[ai].write; hsize = vq[ai].size;
                issued = 1'b1;
            end else if (rdy) begin
                bus_idle();
            end else begin
                // Stalled bus: a live-looking request that must be ignored.
                hsel0 = (t == 0); hsel2 = (t == 1);
                haddr = $urandom & 32'h0000_00FC; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
            end
            @(posedge clk);
            if (di >= 0) begin
                if (rdy) di = -1;
                else k++;
            end
            if (issued) begin
                if (vq[ai].sel && vq[ai].trans[1]) begin
                    di  = ai; k = 0;
                    de  = vq[ai].hand ? vq[ai].exp_err : is_err(vq[ai].addr, vq[ai].size);
                    len = de ? 2 : ((t == 0) ? 1 : WS2 + 1);
                end
                ai++;
            end
            @(negedge clk);
        end
        if (guard >= 20000) begin
            n_chk++;
            $display("FAIL run_timeout[%0d]: got %0d cycles, expected fewer than 20000", t, guard);
        end
        vq.delete();
        bus_idle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog[0]: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl0 [18];
        vec_t tbl2 [5];

        tbl0[0]  = mk(1, 2'b10, 32'h0000_0000, 0, 3'd2, 0, 0, 0, 32'h0302_0100);
        tbl0[1]  = mk(1, 2'b11, 32'h0000_0004, 0, 3'd2, 0, 0, 0, 32'h0706_0504);
        tbl0[2]  = mk(1, 2'b10, 32'h0000_0010, 1, 3'd2, 32'hDEAD_BEEF, 4'b0011, 0, 0);
        tbl0[3]  = mk(1, 2'b10, 32'h0000_0010, 0, 3'd2, 0, 0, 0, 32'h1312_BEEF);
        tbl0[4]  = mk(1, 2'b10, 32'h0000_0020, 1, 3'd2, 32'h1122_3344, 4'b1111, 0, 0);
        tbl0[5]  = mk(1, 2'b10, 32'h0000_0020, 0, 3'd2, 0, 0, 0, 32'h1122_3344);
        tbl0[6]  = mk(1, 2'b10, 32'h0000_0100, 0, 3'd2, 0, 0, 1, 0);
        tbl0[7]  = mk(1, 2'b10, 32'h0000_0002, 1, 3'd2, 32'hFFFF_FFFF, 4'b1111, 1, 0);
        tbl0[8]  = mk(1, 2'b10, 32'h0000_0000, 0, 3'd2, 0, 0, 0, 32'h0302_0100);
        tbl0[9]  = mk(1, 2'b10, 32'h0000_0003, 0, 3'd0, 0, 0, 0, 32'h0302_0100);
        tbl0[10] = mk(1, 2'b10, 32'h0000_0001, 0, 3'd1, 0, 0, 1, 0);
        tbl0[11] = mk(1, 2'b10, 32'h0000_0002, 0, 3'd1, 0, 0, 0, 32'h0302_0100);
        tbl0[12] = mk(1, 2'b10, 32'h0000_00FC, 0, 3'd2, 0, 0, 0, 32'hFFFE_FDFC);
        tbl0[13] = mk(1, 2'b10, 32'h0000_0008, 0, 3'd3, 0, 0, 1, 0);
        tbl0[14] = mk(1, 2'b00, 32'h0000_0008, 0, 3'd2, 0, 0, 0, 0);
        tbl0[15] = mk(0, 2'b10, 32'h0000_0008, 0, 3'd2, 0, 0, 0, 0);
        tbl0[16] = mk(1, 2'b01, 32'h0000_0008, 0, 3'd2, 0, 0, 0, 0);
        tbl0[17] = mk(1, 2'b10, 32'h1000_0008, 0, 3'd2, 0, 0, 0, 32'h0B0A_0908);

        tbl2[0]  = mk(1, 2'b10, 32'h0000_0004, 0, 3'd2, 0, 0, 0, 32'h0706_0504);
        tbl2[1]  = mk(1, 2'b10, 32'h0000_0100, 0, 3'd2, 0, 0, 1, 0);
        tbl2[2]  = mk(1, 2'b10, 32'h0000_0024, 1, 3'd2, 32'hCAFE_F00D, 4'b1010, 0, 0);
        tbl2[3]  = mk(1, 2'b10, 32'h0000_0024, 0, 3'd2, 0, 0, 0, 32'hCA26_F024);
        tbl2[4]  = mk(1, 2'b10, 32'h0000_0000, 0, 3'd2, 0, 0, 0, 32'h0302_0100);

        rst = 1'b1;
        bus_idle();
        hwdata = 32'd0;
        wstrb  = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            dut0.mem[i] <= 8'(i);
            dut2.mem[i] <= 8'(i);
            mdl[0][i] = 8'(i);
            mdl[1][i] = 8'(i);
        end
        exp_hr[0] = 32'd0;
        exp_hr[1] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hreadyout0", 0, 32'(rdy0), 32'd1);
        check("reset_hresp0", 0, 32'(resp0), 32'd0);
        check("reset_hrdata0", 0, hrdata0, 32'd0);
        check("reset_hreadyout2", 0, 32'(rdy2), 32'd1);
        check("reset_hresp2", 0, 32'(resp2), 32'd0);
        check("reset_hrdata2", 0, hrdata2, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) vq.push_back(tbl0[i]);
        run(0);
        for (int i = 0; i < 2; i++) check("err_nowrite", i, 32'(dut0.mem[i + 2]), 32'(i + 2));

        for (int i = 0; i < 5; i++) vq.push_back(tbl2[i]);
        run(1);

        // Reset during a wait cycle of a write: the write must be dropped.
        hsel2 = 1'b1; haddr = 32'h30; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_wait", 0, 32'(rdy2), 32'd0);
        bus_idle();
        hwdata = 32'hAABB_CCDD;
        wstrb  = 4'hF;
        rst    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_hr[0] = 32'd0;
        exp_hr[1] = 32'd0;
        check("rst_mid_hreadyout", 0, 32'(rdy2), 32'd1);
        check("rst_mid_hresp", 0, 32'(resp2), 32'd0);
        check("rst_mid_hrdata2", 0, hrdata2, 32'd0);
        check("rst_mid_hrdata0", 0, hrdata0, 32'd0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) check("rst_mem", i, 32'(dut2.mem[48 + i]), 32'(mdl[1][48 + i]));
        vq.push_back(mk(1, 2'b10, 32'h0000_0030, 0, 3'd2, 0, 0, 0, 32'h3332_3130));
        run(1);

        for (int i = 0; i < 250; i++) vq.push_back(rnd_vec());
        run(0);
        for (int i = 0; i < 150; i++) vq.push_back(rnd_vec());
        run(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
